// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file: global enable, read request/
// address ports, write ports and the registered read-data return path.
interface regfile_mp_if #(
  parameter int DW = 32,
  parameter int AW = 5,
  parameter int NR = 3,
  parameter int NW = 2
);
  logic             en;
  logic [NR-1:0]    rd_req;
  logic [NR*AW-1:0] raddr;
  logic [NW-1:0]    we;
  logic [NW*AW-1:0] waddr;
  logic [NW*DW-1:0] wdata;
  logic [NR*DW-1:0] rdata;
  logic [NR-1:0]    rvalid;

  // Requester side: drives requests, receives read data
  modport master (
    output en, rd_req, raddr, we, waddr, wdata,
    input  rdata, rvalid
  );

  // Register file side: accepts requests, returns read data
  modport slave (
    input  en, rd_req, raddr, we, waddr, wdata,
    output rdata, rvalid
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port GPR array: NR registered read ports, NW write ports,
// optional same-cycle write-to-read forwarding and optional hardwired-zero reg 0.
// Pipeline is array -> read register -> rvalid; there is no state machine.
module regfile_mp #(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = $clog2(DEPTH),
  parameter int NR       = 3,
  parameter int NW       = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  // Upper bound for address range checks, one bit wider than an address so
  // DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

  logic [DW-1:0]    r_mem [DEPTH];
  logic [NR*DW-1:0] r_rdata;
  logic [NR-1:0]    r_rvalid;

  logic [NW-1:0]    w_wr_eff;
  logic [DW-1:0]    w_rd_val [NR];

  // An address names a real, writable/readable register: inside the array and
  // not the hardwired-zero register.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    logic ok;
    ok = ({1'b0, a} < DEPTH_LIM);
    if ((ZERO_REG != 0) && (a == {AW{1'b0}})) begin
      ok = 1'b0;
    end else begin
      ok = ok;
    end
    return ok;
  endfunction

  // Qualify each write port: enabled, requested and aimed at a real register
  always_comb begin
    w_wr_eff = {NW{1'b0}};
    for (int j = 0; j < NW; j++) begin
      w_wr_eff[j] = bus.en & bus.we[j] & addr_ok(bus.waddr[j*AW +: AW]);
    end
  end

  // Per-port read value: array content or zero, overridden by the highest-index
  // matching same-cycle write when forwarding is built in
  always_comb begin
    for (int i = 0; i < NR; i++) begin
      w_rd_val[i] = {DW{1'b0}};
      if (addr_ok(bus.raddr[i*AW +: AW])) begin
        w_rd_val[i] = r_mem[bus.raddr[i*AW +: AW]];
      end else begin
        w_rd_val[i] = {DW{1'b0}};
      end
      if (BYPASS != 0) begin
        for (int j = 0; j < NW; j++) begin
          if (w_wr_eff[j] && (bus.waddr[j*AW +: AW] == bus.raddr[i*AW +: AW])) begin
            w_rd_val[i] = bus.wdata[j*DW +: DW];
          end else begin
            w_rd_val[i] = w_rd_val[i];
          end
        end
      end else begin
        w_rd_val[i] = w_rd_val[i];
      end
    end
  end

  // Array update; later ports overwrite earlier ones so the highest index wins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        r_mem[k] <= {DW{1'b0}};
      end
    end else if (bus.en) begin
      for (int j = 0; j < NW; j++) begin
        if (w_wr_eff[j]) begin
          r_mem[bus.waddr[j*AW +: AW]] <= bus.wdata[j*DW +: DW];
        end
      end
    end
  end

  // Read register: capture requested values, flag them valid for one cycle,
  // hold data when a port is idle or the file is frozen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata  <= {(NR*DW){1'b0}};
      r_rvalid <= {NR{1'b0}};
    end else if (bus.en) begin
      r_rvalid <= bus.rd_req;
      for (int i = 0; i < NR; i++) begin
        if (bus.rd_req[i]) begin
          r_rdata[i*DW +: DW] <= w_rd_val[i];
        end
      end
    end else begin
      r_rvalid <= {NR{1'b0}};
    end
  end

  assign bus.rdata  = r_rdata;
  assign bus.rvalid = r_rvalid;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: a default instance (forwarding on, DEPTH=32)
// and a second instance (forwarding off, DEPTH=24) driven with identical stimulus.
module tb_regfile_mp;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 3;
  localparam int NW = 2;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) a ();
  regfile_mp_if #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) b ();

  assign b.en     = a.en;
  assign b.rd_req = a.rd_req;
  assign b.raddr  = a.raddr;
  assign b.we     = a.we;
  assign b.waddr  = a.waddr;
  assign b.wdata  = a.wdata;

  regfile_mp #(.DW(DW), .DEPTH(32), .AW(AW), .NR(NR), .NW(NW),
               .ZERO_REG(1), .BYPASS(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (a)
  );

  regfile_mp #(.DW(DW), .DEPTH(24), .AW(AW), .NR(NR), .NW(NW),
               .ZERO_REG(1), .BYPASS(0)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (b)
  );

  // Free-running clock, rising edge at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    a.en     = 1'b1;
    a.rd_req = '0;
    a.raddr  = '0;
    a.we     = '0;
    a.waddr  = '0;
    a.wdata  = '0;
  endtask

  task automatic rd(input int i, input logic [AW-1:0] addr);
    a.rd_req[i]        = 1'b1;
    a.raddr[i*AW +: AW] = addr;
  endtask

  task automatic wr(input int j, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    a.we[j]             = 1'b1;
    a.waddr[j*AW +: AW] = addr;
    a.wdata[j*DW +: DW] = data;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    clr();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata_a",  a.rdata,  96'h0);
    chk("reset_rvalid_a", a.rvalid, 96'h0);
    chk("reset_rvalid_b", b.rvalid, 96'h0);
    rst = 1'b0;

    // Reset mid-operation
    clr(); wr(0, 5'd5, 32'hA5); step();
    clr(); rd(0, 5'd5); step();
    chk("pre_reset_rd5_a", a.rdata[31:0], 96'hA5);
    chk("pre_reset_rd5_b", b.rdata[31:0], 96'hA5);
    chk("pre_reset_rvalid", a.rvalid, 96'h1);
    rst = 1'b1;
    #2;
    chk("midreset_rdata_a",  a.rdata,  96'h0);
    chk("midreset_rvalid_a", a.rvalid, 96'h0);
    chk("midreset_rdata_b",  b.rdata,  96'h0);
    rst = 1'b0;
    clr(); rd(0, 5'd5); step();
    chk("post_reset_rd5", a.rdata[31:0], 96'h0);
    chk("post_reset_rvalid", a.rvalid, 96'h1);

    // Basic write then read on all ports
    clr(); wr(0, 5'd3, 32'h1234); step();
    clr(); rd(0, 5'd3); rd(1, 5'd3); rd(2, 5'd3); step();
    chk("basic_rdata", a.rdata, {3{32'h1234}});
    chk("basic_rvalid", a.rvalid, 96'h7);
    clr(); step();
    chk("idle_rvalid", a.rvalid, 96'h0);
    chk("idle_rdata_held", a.rdata, {3{32'h1234}});

    // Same-cycle write/read forwarding
    clr(); wr(0, 5'd7, 32'h11); step();
    clr(); wr(1, 5'd7, 32'h22); rd(0, 5'd7); step();
    chk("bypass_on", a.rdata[31:0], 96'h22);
    chk("bypass_off", b.rdata[31:0], 96'h11);
    clr(); rd(0, 5'd7); step();
    chk("bypass_off_later", b.rdata[31:0], 96'h22);

    // Write collision: highest port wins, also when forwarded
    clr(); wr(0, 5'd9, 32'hAA); wr(1, 5'd9, 32'hBB); step();
    clr(); rd(2, 5'd9); step();
    chk("collision_a", a.rdata[95:64], 96'hBB);
    chk("collision_b", b.rdata[95:64], 96'hBB);
    clr(); wr(0, 5'd10, 32'hCC); wr(1, 5'd10, 32'hDD); rd(1, 5'd10); step();
    chk("collision_bypass_a", a.rdata[63:32], 96'hDD);
    chk("collision_nobypass_b", b.rdata[63:32], 96'h0);

    // Zero register and out-of-range address
    clr(); wr(0, 5'd0, 32'hFF); wr(1, 5'd30, 32'h77); rd(2, 5'd0); step();
    chk("zero_no_bypass", a.rdata[95:64], 96'h0);
    clr(); rd(0, 5'd0); rd(1, 5'd30); step();
    chk("zero_reg_a", a.rdata[31:0], 96'h0);
    chk("inrange30_a", a.rdata[63:32], 96'h77);
    chk("zero_reg_b", b.rdata[31:0], 96'h0);
    chk("outrange30_b", b.rdata[63:32], 96'h0);

    // Freeze with en=0
    clr(); wr(0, 5'd4, 32'h44); step();
    clr(); rd(1, 5'd4); step();
    chk("freeze_setup", a.rdata[63:32], 96'h44);
    clr(); a.en = 1'b0; wr(0, 5'd4, 32'h99); rd(0, 5'd4); rd(1, 5'd4); rd(2, 5'd4); step();
    chk("freeze_rvalid_a", a.rvalid, 96'h0);
    chk("freeze_rvalid_b", b.rvalid, 96'h0);
    chk("freeze_rdata_held", a.rdata, {32'h0, 32'h44, 32'h0});
    clr(); rd(1, 5'd4); step();
    chk("freeze_old_value", a.rdata[63:32], 96'h44);
    chk("freeze_after_rvalid", a.rvalid, 96'h2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
